ext_intr_ctrl: RTL and testbench
================================

// Module: ext_intr_ctrl
// PURPOSE
//  External interrupt controller between the SoC's async interrupt pins and the c7b core.
//  Synchronises NUM_SRC lines; captures them as edge- or level-triggered; masks them.
//  Picks one source by fixed priority and offers it to the core over a req/ack/eoi handshake.
//  Sits in top, beside u_c7b; replaces the single raw ext_intr wire into the core.
// PARAMETERS
//  NUM_SRC      8  number of interrupt sources (1..16)
//  ID_W         3  width of intr_id; must be >= clog2(NUM_SRC)
//  SYNC_STAGES  2  synchroniser flops per source (>=2)
// PORTS
//  clk        in   1        core clock
//  reset      in   1        async reset, active-high
//  ext_intr   in   NUM_SRC  raw async interrupt lines, active-high
//  cfg_we     in   1        config write strobe
//  cfg_addr   in   2        0=ENABLE 1=MODE (1=rising edge, 0=level) 2=PENDING 3=STATUS
//  cfg_wdata  in   NUM_SRC  config write data
//  cfg_rdata  out  NUM_SRC  config read data (registered)
//  intr_req   out  1        interrupt offered to core
//  intr_id    out  ID_W     source number offered or in service
//  intr_ack   in   1        core takes the interrupt (1 cycle)
//  intr_eoi   in   1        core finished the handler (1 cycle)
// BEHAVIOUR
//  Reset (async, active-high):
//   - enable, mode, pending, sync flops, prev-sample, cfg_rdata, intr_id: all 0.
//   - FSM in IDLE; intr_req=0.
//  Capture path:
//   - s[i] is the SYNC_STAGES-deep synchronised ext_intr[i].
//   - Edge mode: pending[i] is set on s[i] & ~prev[i] and stays set (sticky).
//   - Level mode: pending[i] = s[i] (not latched).
//   - A pin rise first shows in pending SYNC_STAGES+1 clocks later.
//   - elig = pending & enable.
//  Config:
//   - ENABLE and MODE writes take effect the next cycle.
//   - PENDING write: write-1-to-clear, edge-mode bits only.
//   - A hardware set in the same cycle beats the W1C clear.
//   - STATUS reads {in_service, intr_id} zero-extended; writes to STATUS are ignored.
//   - cfg_rdata = register at cfg_addr, sampled one cycle earlier (1-cycle read latency).
//  FSM states: IDLE, REQ, SERVICE.
//   - IDLE: if elig!=0, next cycle REQ with intr_req=1 and intr_id = lowest set index of elig.
//   - REQ: intr_id is frozen.
//     - intr_ack=1 -> SERVICE; intr_req=0 the next cycle. If the source is edge mode, its
//       pending bit clears on the same edge (a new edge in that cycle re-sets it).
//     - No ack and elig[intr_id]==0 (level drop or enable cleared) -> IDLE, intr_req=0.
//     - Ack and withdrawal in the same cycle: ack wins.
//   - SERVICE: intr_req=0. No nesting; new pendings wait. intr_eoi=1 -> IDLE.
//     The earliest re-request is 1 cycle after the eoi cycle.
//   - intr_ack outside REQ is ignored. intr_eoi outside SERVICE is ignored.
//     Simultaneous ack+eoi acts as ack only.
//  Reset mid-handshake: the FSM drops to IDLE immediately and intr_req falls asynchronously.
// STRUCTURE
//  - Shared package/defines header: FSM state encodings (2b) and cfg address constants
//    INTC_ENABLE/MODE/PENDING/STATUS.
//  - Sub-module ext_intr_sync_edge, instanced once per source by generate: synchroniser,
//    prev flop, rise pulse.
//  - Priority encoder, FSM and cfg registers live in this module.
// TESTING
//  1. Reset with ext_intr=8'hFF.
//     -> intr_req=0, cfg_rdata=0 throughout reset; nothing pending until ENABLE is written.
//  2. ENABLE=8'h01, MODE=8'h01, pulse ext_intr[0] for 1 clk.
//     -> intr_req=1 with intr_id=0 by clk 4 after the pulse.
//     -> ack clears PENDING[0]; eoi returns to IDLE; no second req.
//  3. ENABLE=8'hFF, level mode, raise lines 5 and 2 together.
//     -> intr_id=2 first. After ack+eoi with line 2 low, intr_id=5 within 2 clks.
//  4. Level source 3 in REQ, drop ext_intr[3] before ack.
//     -> intr_req falls SYNC_STAGES+1 clks after the drop; FSM back in IDLE; a late ack is ignored.
//  5. In SERVICE, edge source 6 fires.
//     -> no req until eoi; then intr_req=1 with intr_id=6 on the 2nd clk after eoi.
//  6. Edge source 1 pending; same cycle: W1C PENDING=8'h02 plus a new synchronised rise.
//     -> PENDING[1] stays 1. Assert reset during REQ -> intr_req=0 at once.

Source files
------------

// File: rtl/ext_intr_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: FSM encoding,
// config register map and the fixed-priority helper.
package ext_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  localparam logic [1:0] INTC_ENABLE  = 2'd0;
  localparam logic [1:0] INTC_MODE    = 2'd1;
  localparam logic [1:0] INTC_PENDING = 2'd2;
  localparam logic [1:0] INTC_STATUS  = 2'd3;

  localparam int MAX_SRC = 16;

  // Index of the lowest set bit; source 0 has the highest priority.
  function automatic logic [3:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ext_intr_sync_edge.sv
// Per-source synchroniser for an async interrupt pin, plus the previous-sample
// flop that turns the synchronised level into a one-cycle rise pulse.
module ext_intr_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ext_intr_ctrl.sv
// External interrupt controller: synchronise, capture (edge/level), mask,
// pick the lowest-numbered eligible source and hand it to the core via req/ack/eoi.
module ext_intr_ctrl
  import ext_intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] ext_intr,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic               intr_req,
  output logic [ID_W-1:0]    intr_id,
  input  logic               intr_ack,
  input  logic               intr_eoi
);

  localparam int STW = NUM_SRC + ID_W + 1;

  intc_state_e        state_reg;
  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] mode_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] pending_view;
  logic [NUM_SRC-1:0] sync_s;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] id_onehot;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] status_word;
  logic [NUM_SRC-1:0] rdata_next;
  logic [STW-1:0]     status_ext;
  logic [ID_W-1:0]    prio_id;
  logic               ack_take;
  logic               cur_elig;

  assign ack_take = (state_reg == ST_REQ) && intr_ack;
  assign w1c_mask = (cfg_we && (cfg_addr == INTC_PENDING)) ? cfg_wdata : '0;
  assign ack_mask = ack_take ? id_onehot : '0;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      ext_intr_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_intr[gi]),
        .sync_out (sync_s[gi]),
        .rise     (rise[gi])
      );

      assign id_onehot[gi] = (intr_id == ID_W'(gi));

      // A rise in the same cycle as a clear (W1C or ack) wins; level bits never latch.
      assign pending_next[gi] = mode_reg[gi] &
                                ((pending_reg[gi] & ~(w1c_mask[gi] | ack_mask[gi])) | rise[gi]);
      assign pending_view[gi] = mode_reg[gi] ? pending_reg[gi] : sync_s[gi];
    end
  endgenerate

  assign elig     = pending_view & enable_reg;
  assign cur_elig = |(elig & id_onehot);
  assign prio_id  = ID_W'(lowest_set(MAX_SRC'(elig)));

  assign status_ext  = STW'({(state_reg == ST_SERVICE), intr_id});
  assign status_word = status_ext[NUM_SRC-1:0];

  always_comb begin
    rdata_next = '0;
    case (cfg_addr)
      INTC_ENABLE:  rdata_next = enable_reg;
      INTC_MODE:    rdata_next = mode_reg;
      INTC_PENDING: rdata_next = pending_view;
      default:      rdata_next = status_word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg  <= '0;
      mode_reg    <= '0;
      pending_reg <= '0;
      cfg_rdata   <= '0;
    end else begin
      pending_reg <= pending_next;
      cfg_rdata   <= rdata_next;
      if (cfg_we && (cfg_addr == INTC_ENABLE)) enable_reg <= cfg_wdata;
      if (cfg_we && (cfg_addr == INTC_MODE))   mode_reg   <= cfg_wdata;
    end
  end

  // intr_id stays frozen from the offer through service so STATUS reports it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      intr_req  <= 1'b0;
      intr_id   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|elig) begin
            state_reg <= ST_REQ;
            intr_req  <= 1'b1;
            intr_id   <= prio_id;
          end
        end
        ST_REQ: begin
          if (intr_ack) begin
            state_reg <= ST_SERVICE;
            intr_req  <= 1'b0;
          end else if (!cur_elig) begin
            state_reg <= ST_IDLE;
            intr_req  <= 1'b0;
          end
        end
        ST_SERVICE: begin
          intr_req <= 1'b0;
          if (intr_eoi) state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          intr_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed bench for ext_intr_ctrl with a cycle model checked on every falling edge.
module tb_ext_intr_ctrl;
  import ext_intr_ctrl_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;
  localparam int SS      = 2;
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_SVC   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] ext_intr;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_SRC-1:0] cfg_wdata;
  logic [NUM_SRC-1:0] cfg_rdata;
  logic               intr_req;
  logic [ID_W-1:0]    intr_id;
  logic               intr_ack;
  logic               intr_eoi;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ext_intr_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .ID_W        (ID_W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_intr  (ext_intr),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .intr_req  (intr_req),
    .intr_id   (intr_id),
    .intr_ack  (intr_ack),
    .intr_eoi  (intr_eoi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_en, m_mode, m_pend, m_rdata;
  logic [2:0] m_id;
  logic       m_req;
  int         m_state;
  logic [7:0] hist[$];   // hist[0] = newest pin sample
  logic [7:0] t_s, t_prev, t_rise, t_view, t_elig, t_clr, t_stat;

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_en = 0; m_mode = 0; m_pend = 0; m_rdata = 0; m_id = 0; m_req = 0;
      m_state = M_IDLE;
      hist = {};
      for (int k = 0; k <= SS; k++) hist.push_back(8'h00);
    end else begin
      t_s    = hist[SS-1];
      t_prev = hist[SS];
      t_rise = t_s & ~t_prev;
      t_view = (m_mode & m_pend) | (~m_mode & t_s);
      t_elig = t_view & m_en;
      t_stat = {4'b0, (m_state == M_SVC), m_id};
      case (cfg_addr)
        INTC_ENABLE:  m_rdata = m_en;
        INTC_MODE:    m_rdata = m_mode;
        INTC_PENDING: m_rdata = t_view;
        default:      m_rdata = t_stat;
      endcase
      t_clr = 8'h00;
      if (cfg_we && cfg_addr == INTC_PENDING) t_clr = cfg_wdata;
      if (m_state == M_REQ && intr_ack) t_clr[m_id] = 1'b1;
      m_pend = m_mode & ((m_pend & ~t_clr) | t_rise);
      case (m_state)
        M_IDLE: if (t_elig != 0) begin
          m_state = M_REQ; m_req = 1'b1; m_id = first_set(t_elig);
        end
        M_REQ: if (intr_ack) begin
          m_state = M_SVC; m_req = 1'b0;
        end else if (!t_elig[m_id]) begin
          m_state = M_IDLE; m_req = 1'b0;
        end
        default: if (intr_eoi) m_state = M_IDLE;
      endcase
      if (cfg_we && cfg_addr == INTC_ENABLE) m_en = cfg_wdata;
      if (cfg_we && cfg_addr == INTC_MODE)   m_mode = cfg_wdata;
      hist.push_front(ext_intr);
      void'(hist.pop_back());
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("model_req", 32'(intr_req), 32'(m_req));
    check("model_rdata", 32'(cfg_rdata), 32'(m_rdata));
    if (m_state != M_IDLE) check("model_id", 32'(intr_id), 32'(m_id));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick(1);
    cfg_we = 1'b0;
    $display("cfg write addr=%0d data=%02h", addr, data);
  endtask

  initial begin
    reset = 1'b1; ext_intr = 8'hFF; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    intr_ack = 0; intr_eoi = 0;
    tick(3);
    check("rst_req", 32'(intr_req), 32'd0);
    check("rst_rdata", 32'(cfg_rdata), 32'd0);
    reset = 1'b0;
    tick(5);
    check("t1_no_req", 32'(intr_req), 32'd0);
    ext_intr = 8'h00;
    tick(4);
    $display("t1 reset with lines high done");

    cfg_write(INTC_ENABLE, 8'h01);
    cfg_write(INTC_MODE, 8'h01);
    ext_intr = 8'h01; tick(1); ext_intr = 8'h00;
    tick(2);
    check("t2_req_early", 32'(intr_req), 32'd0);
    tick(1);
    check("t2_req", 32'(intr_req), 32'd1);
    check("t2_id", 32'(intr_id), 32'd0);
    intr_ack = 1; tick(1); intr_ack = 0; cfg_addr = INTC_PENDING;
    tick(1);
    check("t2_pend_clr", 32'(cfg_rdata), 32'd0);
    intr_eoi = 1; tick(1); intr_eoi = 0;
    tick(3);
    check("t2_no_second", 32'(intr_req), 32'd0);
    $display("t2 edge source 0 handshake done");

    cfg_write(INTC_MODE, 8'h00);
    cfg_write(INTC_ENABLE, 8'hFF);
    ext_intr = 8'h24;
    tick(3);
    check("t3_req", 32'(intr_req), 32'd1);
    check("t3_id2", 32'(intr_id), 32'd2);
    intr_ack = 1; ext_intr = 8'h20; tick(1); intr_ack = 0;
    tick(3);
    intr_eoi = 1; tick(1); intr_eoi = 0;
    check("t3_gap", 32'(intr_req), 32'd0);
    tick(1);
    check("t3_req5", 32'(intr_req), 32'd1);
    check("t3_id5", 32'(intr_id), 32'd5);
    intr_ack = 1; ext_intr = 8'h00; tick(1); intr_ack = 0;
    tick(3);
    intr_eoi = 1; tick(1); intr_eoi = 0;
    tick(4);
    check("t3_quiet", 32'(intr_req), 32'd0);
    $display("t3 level priority 2 then 5 done");

    ext_intr = 8'h08;
    tick(3);
    check("t4_req", 32'(intr_req), 32'd1);
    check("t4_id3", 32'(intr_id), 32'd3);
    ext_intr = 8'h00;
    tick(2);
    check("t4_still_req", 32'(intr_req), 32'd1);
    tick(1);
    check("t4_withdrawn", 32'(intr_req), 32'd0);
    intr_ack = 1; cfg_addr = INTC_STATUS; tick(1); intr_ack = 0;
    tick(1);
    check("t4_late_ack_req", 32'(intr_req), 32'd0);
    check("t4_not_in_service", 32'(cfg_rdata & 8'h08), 32'd0);
    $display("t4 level withdrawal done");

    cfg_write(INTC_MODE, 8'h40);
    ext_intr = 8'h10;
    tick(3);
    check("t5_id4", 32'(intr_id), 32'd4);
    intr_ack = 1; ext_intr = 8'h00; tick(1); intr_ack = 0;
    ext_intr = 8'h40; tick(1); ext_intr = 8'h00;
    tick(4);
    check("t5_held", 32'(intr_req), 32'd0);
    intr_eoi = 1; tick(1); intr_eoi = 0;
    check("t5_gap", 32'(intr_req), 32'd0);
    tick(1);
    check("t5_req6", 32'(intr_req), 32'd1);
    check("t5_id6", 32'(intr_id), 32'd6);
    intr_ack = 1; tick(1); intr_ack = 0;
    tick(2);
    intr_eoi = 1; tick(1); intr_eoi = 0;
    tick(2);
    $display("t5 no nesting, source 6 after eoi done");

    cfg_write(INTC_MODE, 8'h42);
    ext_intr = 8'h02; tick(1); ext_intr = 8'h00;
    tick(3);
    check("t6_req1", 32'(intr_req), 32'd1);
    ext_intr = 8'h02; tick(1); ext_intr = 8'h00;
    tick(1);
    cfg_we = 1; cfg_addr = INTC_PENDING; cfg_wdata = 8'h02;
    tick(1);
    cfg_we = 0;
    tick(1);
    check("t6_set_beats_w1c", 32'(cfg_rdata & 8'h02), 32'h02);
    cfg_write(INTC_PENDING, 8'h02);
    tick(1);
    check("t6_w1c_clears", 32'(cfg_rdata & 8'h02), 32'h00);
    ext_intr = 8'h02; tick(1); ext_intr = 8'h00;
    tick(3);
    check("t6_req_before_rst", 32'(intr_req), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_async_rst", 32'(intr_req), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("t6_after_rst", 32'(intr_req), 32'd0);
    $display("t6 W1C race and async reset done");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
